// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter: ALU results go straight through, load results wait in a
// 2-entry FIFO, and a starvation counter forces the FIFO head through after STARVE_LIMIT losses.
module regfile_wr_arbiter #(
    parameter int STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [4:0]  a_reg,
    input  logic [31:0] a_data,
    input  logic        a_link,
    output logic        a_ready,
    input  logic        l_valid,
    input  logic [4:0]  l_reg,
    input  logic [31:0] l_data,
    output logic        l_ready,
    output logic        RegWrite,
    output logic [4:0]  writeR,
    output logic [31:0] writedata,
    input  logic [4:0]  readR1,
    input  logic [4:0]  readR2,
    output logic        busy1,
    output logic        busy2
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    // Handshake: a request transfers on a rising edge where its valid and ready are both 1.
    // a_ready and l_ready depend only on registered state, never on any input.
    logic [4:0]    q_reg  [2];
    logic [31:0]   q_data [2];
    logic          hd;
    logic [1:0]    count;
    logic [SW-1:0] starve;

    logic        starved;
    logic        alu_grant;
    logic        pop;
    logic        push;
    logic        grant;
    logic        tail;
    logic [4:0]  dest;
    logic [31:0] data;

    always_comb begin
        starved   = (starve == SW'(STARVE_LIMIT));
        a_ready   = !starved;
        l_ready   = (count != 2'd2);
        alu_grant = a_valid && !starved;
        pop       = (count != 2'd0) && !alu_grant;
        push      = l_valid && l_ready;
        grant     = alu_grant || pop;
        tail      = hd ^ count[0];
        dest      = q_reg[hd];
        data      = q_data[hd];
        if (alu_grant) begin
            dest = a_link ? 5'd31 : a_reg;
            data = a_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 2; i++) begin
                q_reg[i]  <= '0;
                q_data[i] <= '0;
            end
            hd     <= 1'b0;
            count  <= 2'd0;
            starve <= '0;
        end else begin
            if (push) begin
                q_reg[tail]  <= l_reg;
                q_data[tail] <= l_data;
            end
            hd    <= hd ^ pop;
            count <= count + 2'(push) - 2'(pop);
            // Counter only runs while a load is waiting and loses to the ALU.
            if (pop || count == 2'd0)
                starve <= '0;
            else if (alu_grant && !starved)
                starve <= starve + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            RegWrite  <= 1'b0;
            writeR    <= '0;
            writedata <= '0;
        end else begin
            RegWrite <= grant && (dest != 5'd0);
            if (grant) begin
                writeR    <= dest;
                writedata <= data;
            end
        end
    end

    // A read is busy while its register is still queued or is being written this cycle.
    always_comb begin
        busy1 = (readR1 != 5'd0) &&
                (((count != 2'd0) && (q_reg[hd] == readR1)) ||
                 ((count == 2'd2) && (q_reg[~hd] == readR1)) ||
                 (RegWrite && (writeR == readR1)));
        busy2 = (readR2 != 5'd0) &&
                (((count != 2'd0) && (q_reg[hd] == readR2)) ||
                 ((count == 2'd2) && (q_reg[~hd] == readR2)) ||
                 (RegWrite && (writeR == readR2)));
    end
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: queue-based reference model feeds an expected-write scoreboard
// that a negedge monitor drains whenever RegWrite is presented.
module tb_regfile_wr_arbiter;
    localparam int LIMIT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_valid, a_link, l_valid;
    logic [4:0]  a_reg, l_reg, readR1, readR2;
    logic [31:0] a_data, l_data;
    logic        a_ready, l_ready, RegWrite, busy1, busy2;
    logic [4:0]  writeR;
    logic [31:0] writedata;

    regfile_wr_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset),
        .a_valid(a_valid), .a_reg(a_reg), .a_data(a_data), .a_link(a_link), .a_ready(a_ready),
        .l_valid(l_valid), .l_reg(l_reg), .l_data(l_data), .l_ready(l_ready),
        .RegWrite(RegWrite), .writeR(writeR), .writedata(writedata),
        .readR1(readR1), .readR2(readR2), .busy1(busy1), .busy2(busy2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model state
    logic [36:0] exp_q[$];
    int          exp_cyc_q[$];
    logic [36:0] load_q[$];
    int          starve = 0;
    logic        pend_we = 1'b0;
    logic [4:0]  pend_reg = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic busy_of(input logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (load_q[i]) if (load_q[i][36:32] == r) return 1'b1;
        return pend_we && (pend_reg == r);
    endfunction

    // One clock of stimulus; the model decides what the next edge does.
    task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad, input logic al,
                        input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                        input logic [4:0] r1, input logic [4:0] r2);
        bit          starved, accept, wr;
        logic [4:0]  dst;
        logic [31:0] dat;
        @(negedge clk);
        a_valid = av; a_reg = ar; a_data = ad; a_link = al;
        l_valid = lv; l_reg = lr; l_data = ld; readR1 = r1; readR2 = r2;
        #1;
        starved = (load_q.size() > 0) && (starve >= LIMIT);
        chk("a_ready", 64'(a_ready), 64'(!starved));
        chk("l_ready", 64'(l_ready), 64'(load_q.size() < 2));
        chk("busy1", 64'(busy1), 64'(busy_of(r1)));
        chk("busy2", 64'(busy2), 64'(busy_of(r2)));
        chk("RegWrite", 64'(RegWrite), 64'(pend_we));
        accept = lv && (load_q.size() < 2);
        wr = 1'b0;
        dst = '0;
        dat = '0;
        if (av && !starved) begin
            wr = 1'b1;
            dst = al ? 5'd31 : ar;
            dat = ad;
            starve = (load_q.size() > 0) ? ((starve + 1 > LIMIT) ? LIMIT : starve + 1) : 0;
        end else if (load_q.size() > 0) begin
            {dst, dat} = load_q.pop_front();
            wr = 1'b1;
            starve = 0;
        end else begin
            starve = 0;
        end
        if (accept) load_q.push_back({lr, ld});
        pend_we = wr && (dst != 5'd0);
        if (wr) pend_reg = dst;
        if (pend_we) begin
            exp_q.push_back({dst, dat});
            exp_cyc_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_steps(input int n);
        for (int i = 0; i < n; i++)
            step($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                 $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 7)), $urandom,
                 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_RegWrite"}, 64'(RegWrite), 64'(0));
        chk({tag, "_writeR"}, 64'(writeR), 64'(0));
        chk({tag, "_writedata"}, 64'(writedata), 64'(0));
        chk({tag, "_l_ready"}, 64'(l_ready), 64'(1));
        chk({tag, "_a_ready"}, 64'(a_ready), 64'(1));
    endtask

    // Monitor: every presented write must match the head of the expected queue, on time.
    always @(negedge clk) begin : monitor
        logic [36:0] e;
        int          ec;
        if (reset === 1'b1 && RegWrite === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write actual=%0d:%0h required=none", writeR, writedata);
            end else begin
                e  = exp_q.pop_front();
                ec = exp_cyc_q.pop_front();
                chk("write", 64'({writeR, writedata}), 64'(e));
                chk("write_cycle", 64'(cyc), 64'(ec));
            end
        end
    end

    initial begin
        a_valid = 0; a_reg = 0; a_data = 0; a_link = 0;
        l_valid = 0; l_reg = 0; l_data = 0; readR1 = 0; readR2 = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        #2 check_reset_outputs("init");
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;

        // ALU-only write
        step(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0);
        // Link redirect, then destination 0 suppressed
        step(1, 0, 32'h00400008, 1, 0, 0, 0, 0, 0);
        step(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 0);
        idle(2);
        // Starvation: one load against a continuous ALU stream
        step(1, 1, 32'h100, 0, 1, 7, 32'h11, 7, 0);
        for (int i = 0; i < 6; i++) step(1, 5'(2 + i), 32'(i), 0, 0, 0, 0, 7, 0);
        idle(2);
        // Full FIFO: two loads, a refused third, then drain in order
        step(1, 3, 32'hA, 0, 1, 10, 32'hAAAA, 0, 0);
        step(1, 3, 32'hB, 0, 1, 11, 32'hBBBB, 0, 0);
        step(1, 3, 32'hC, 0, 1, 12, 32'hCCCC, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 10, 11);
        idle(3);
        // Hazard on a queued load
        step(1, 4, 32'h44, 0, 1, 9, 32'h99, 9, 0);
        step(1, 4, 32'h45, 0, 0, 0, 0, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 9, 0);
        step(0, 0, 0, 0, 0, 0, 0, 9, 0);

        rand_steps(400);

        // Reset mid-operation with two loads queued
        step(1, 6, 32'h66, 0, 1, 3, 32'h33, 0, 0);
        step(1, 6, 32'h67, 0, 1, 4, 32'h34, 0, 0);
        @(negedge clk);
        a_valid = 0; l_valid = 0;
        #2 reset = 1'b0;
        #1 check_reset_outputs("midreset");
        load_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
        starve = 0;
        pend_we = 1'b0;
        #1 reset = 1'b1;
        idle(3);

        rand_steps(200);
        idle(6);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_wr_arbiter.md
REGFILE_WR_ARBITER -- requirements
Module: regfile_wr_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 3, meaning the maximum number of consecutive cycles a queued load result may lose arbitration to the ALU port.
REQ-002 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ALU request ports a_valid (in, 1), a_reg (in, 5), a_data (in, 32), a_link (in, 1) and a_ready (out, 1).
REQ-005 SHALL have load request ports l_valid (in, 1), l_reg (in, 5), l_data (in, 32) and l_ready (out, 1).
REQ-006 SHALL have register-file write outputs RegWrite (out, 1), writeR (out, 5) and writedata (out, 32).
REQ-007 SHALL have hazard inputs readR1 and readR2 (in, 5 each) and outputs busy1 and busy2 (out, 1 each).

Function
REQ-008 SHALL transfer an ALU request when a_valid & a_ready, and a load request when l_valid & l_ready, on the rising clock edge.
REQ-009 SHALL hold load requests in a 2-entry FIFO; l_ready = (count < 2), decoded from registered state only, with no combinational path from any input.
REQ-010 SHALL accept a simultaneous enqueue and dequeue when count == 1; when count == 2 the FIFO SHALL refuse the enqueue even in a dequeue cycle.
REQ-011 SHALL grant the ALU port each cycle a_valid = 1, unless the starvation counter equals STARVE_LIMIT, in which case the FIFO head is granted and a_ready = 0.
REQ-012 SHALL drive a_ready = 1 in every other cycle, independent of a_valid.
REQ-013 SHALL grant and pop the FIFO head when a_valid = 0 and count > 0.
REQ-014 SHALL increment the starvation counter (saturating at STARVE_LIMIT) each cycle count > 0 and the ALU is granted, and clear it on any FIFO pop or when count == 0.
REQ-015 SHALL register the granted request into RegWrite/writeR/writedata, giving exactly one cycle of latency from handshake to register-file write.
REQ-016 SHALL redirect an ALU request with a_link = 1 to writeR = 31, regardless of a_reg.
REQ-017 SHALL consume a granted request whose destination is 0 but drive RegWrite = 0 for it; writeR and writedata are don't-care in that cycle.
REQ-018 SHALL drive RegWrite = 0 in any cycle following a cycle with no grant.
REQ-019 SHALL assert busy1 when readR1 != 0 and readR1 matches a valid FIFO entry's reg or the pending output (RegWrite = 1 and writeR); busy2 SHALL follow the same rule for readR2.
REQ-020 SHALL evaluate busy1 and busy2 combinationally in the same cycle.
REQ-021 SHALL preserve FIFO order: load results are written in acceptance order.
REQ-022 SHALL treat ALU results as never queued; an ALU request is either written or held off via a_ready.

Reset
REQ-023 SHALL, on reset = 0, immediately clear the FIFO (count = 0), the starvation counter, RegWrite, writeR and writedata, and drive l_ready = 1 and a_ready = 1.
REQ-024 SHALL discard queued or in-flight entries when reset asserts mid-operation; no write SHALL occur until a new handshake after reset releases.
REQ-025 SHALL produce its first possible write in the second rising edge after reset deasserts, i.e. one edge to accept, one edge to register.

Verification
REQ-026 ALU only: a_valid = 1, a_reg = 5, a_data = 0xDEADBEEF -> next cycle RegWrite = 1, writeR = 5, writedata = 0xDEADBEEF.
REQ-027 Link: a_link = 1, a_reg = 0, a_data = 0x00400008 -> next cycle writeR = 31, RegWrite = 1; with a_link = 0, a_reg = 0 -> RegWrite = 0.
REQ-028 Starvation: enqueue load (reg 7, data 0x11) and hold a_valid = 1 continuously -> ALU wins 3 cycles, then a_ready = 0 for 1 cycle and writeR = 7 in the following cycle, then a_ready = 1.
REQ-029 Full FIFO: two loads queued while a_valid = 1 -> l_ready = 0; a third l_valid is not accepted; after a_valid drops, loads are written in order on consecutive cycles.
REQ-030 Hazard: load to reg 9 queued, readR1 = 9, readR2 = 0 -> busy1 = 1 and busy2 = 0; busy1 stays 1 through the write cycle and clears the cycle after.
REQ-031 Reset mid-operation: two loads queued, reset pulsed low between edges -> outputs clear asynchronously, l_ready = 1, and no stale writes appear afterwards.
